pipe_stage_register: RTL and testbench
======================================

Name: pipe_stage_register

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage datapath. It supersedes the fixed-field per-stage registers.
- Carries one control bundle and one packed data bundle per beat.
- Adds valid/ready flow control, synchronous flush (bubble insertion) and an optional 2-entry skid buffer, so stalls do not create combinational ready paths.
- Instantiated once per stage boundary (D->E, E->M, M->W), with widths set per boundary.

Parameters:
- CTRL_W, 11, width of the control bundle. Controls are forced to zero whenever the stage holds a bubble.
- DATA_W, 143, width of the packed data bundle. Default = rd1 32 + rd2 32 + imm 32 + upperimm 32 + rs/rt/rd 15.
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  stage clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all held beats (hazard/branch kill).
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_ctrl  input  CTRL_W  upstream controls.
- in_data  input  DATA_W  upstream data.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts the beat this cycle (low = stall).
- out_ctrl  output  CTRL_W  controls of the head beat; zero when out_valid=0.
- out_data  output  DATA_W  data of the head beat; holds its last value when out_valid=0.
- occupancy  output  2  number of held beats (0..2; max 1 when SKID_EN=0).

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - At most one beat is accepted and one beat delivered per cycle.
- Reset (async, active-high): state EMPTY; main and skid registers cleared to 0; out_valid=0; out_ctrl=0; out_data=0; occupancy=0.
  - in_ready reset value: 1 when SKID_EN=1; follows its equation when SKID_EN=0.
  - Reset mid-transfer discards all held beats.
- Latency: 1 cycle from in_fire to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Beats leave in acceptance order. Beats are never duplicated or dropped except by flush or reset.
- SKID_EN=1 state machine (out_data always driven from the main register):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> TWO, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, no fire -> hold.
  - TWO: in_ready=0, so no accept.
  - TWO, out_fire -> ONE, main <= skid.
  - TWO, no fire -> hold.
  - in_ready is a flop equal to (next state != TWO). It has no combinational path from out_ready.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - States EMPTY/ONE only; transitions as above minus TWO.
- Flush:
  - At the next edge: state -> EMPTY; out_valid=0; out_ctrl=0; occupancy=0; in_ready=1 (SKID_EN=1).
  - Flush beats everything:
    - an in_fire in the same cycle is dropped;
    - an out_fire in the same cycle still counts downstream (the beat was already presented).
  - out_data is not cleared by flush.
- Bubble rule: out_ctrl equals the main register's ctrl when out_valid=1, and all-zero otherwise. This guarantees no write-enables propagate from a bubble.
- Occupancy: 0/1/2 tracking EMPTY/ONE/TWO, updated on the same edge as the state.
- Protocol:
  - The upstream must hold in_valid/in_ctrl/in_data stable while in_valid=1 & in_ready=0.
  - The stage holds out_valid/out_ctrl/out_data stable while out_valid=1 & out_ready=0.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then in_valid=1 with data 0x1..0x8 and out_ready=1 -> out_valid rises 1 cycle after the first accept; out_data 0x1..0x8 on consecutive cycles; occupancy stays 1; in_ready stays 1.
- Stall/skid (SKID_EN=1): stream 0xA, 0xB, 0xC with out_ready=0 from cycle 1 -> occupancy reaches 2 and in_ready drops to 0 with 0xC held upstream. After out_ready=1, outputs are 0xA, 0xB, 0xC in order with no loss.
- Flush with full buffer: occupancy=2 with ctrl=0x7FF; assert flush together with in_valid carrying 0xD -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xD never appears.
- Bubble controls: in_valid=0 for 3 cycles after a beat with ctrl=0x155 -> out_ctrl=0x000 once that beat drains; out_data keeps its last value.
- SKID_EN=0, out_ready toggling 1,0,1,0 under continuous in_valid -> in_ready mirrors !out_valid|out_ready in the same cycle; occupancy never exceeds 1; all beats delivered in order.
- Async reset mid-stall: occupancy=2, assert reset between clock edges -> out_valid, out_ctrl, out_data and occupancy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_register.sv
// pipe_stage_register: parametrised inter-stage pipeline register.
// Carries one control bundle and one data bundle per beat with valid/ready
// flow control, a synchronous flush that turns the stage into a bubble, and
// an optional second (skid) entry so that in_ready can come from a flop
// instead of a combinational path from out_ready.
module pipe_stage_register #(
  parameter int CTRL_W  = 11,
  parameter int DATA_W  = 143,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding doubles as the occupancy count (0, 1 or 2 held beats).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Main entry is always the head beat; the skid entry holds the second beat.
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign out_valid = (state_reg != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_reg;
  assign out_data  = main_data_reg;

  // Bubble masking: a stage without a valid beat never presents controls,
  // so no write-enable can leak downstream from a killed or empty slot.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign out_ctrl[gi] = main_ctrl_reg[gi] & out_valid;
    end
  endgenerate

  // In-ready source: a flop in skid mode, the classic pass-through otherwise.
  generate
    if (SKID_EN) begin : g_skid_ready
      logic in_ready_reg;

      // Ready for next cycle is simply "the stage will not be full".
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != ST_TWO);
        end
      end

      assign in_ready = in_ready_reg;
    end else begin : g_comb_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // State register: beat count tracking, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept/deliver bookkeeping, flush empties the stage.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          // Unreachable without the skid entry: in_ready implies out_ready.
          state_next = SKID_EN ? ST_TWO : ST_ONE;
        end else if (!in_fire && out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  // Output/strobe logic: decide which register captures what this cycle.
  // A flushed cycle captures nothing, so a killed beat never reaches out_data.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (state_reg)
        ST_EMPTY: begin
          load_main_in = in_fire;
        end
        ST_ONE: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        ST_TWO: begin
          load_main_skid = out_fire;
        end
        default: begin
          load_main_in = 1'b0;
        end
      endcase
    end
  end

  // Main register: takes a fresh beat or promotes the skid beat to the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
    end else if (load_main_in) begin
      main_ctrl_reg <= in_ctrl;
      main_data_reg <= in_data;
    end else if (load_main_skid) begin
      main_ctrl_reg <= skid_ctrl_reg;
      main_data_reg <= skid_data_reg;
    end
  end

  // Skid register: parks the beat accepted while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else if (load_skid) begin
      skid_ctrl_reg <= in_ctrl;
      skid_data_reg <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Testbench for pipe_stage_register: one skid instance (index 0) and one
// pass-through instance (index 1), each compared every cycle against a
// beat-list reference model.
module tb_pipe_stage_register;

  localparam int CW = 11;
  localparam int DW = 143;
  localparam int BW = CW + DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    iv, fl, ordy, ov, ir;
  logic [CW-1:0] ic [2];
  logic [CW-1:0] oc [2];
  logic [DW-1:0] id [2];
  logic [DW-1:0] od [2];
  logic [1:0]    occ [2];

  pipe_stage_register #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .reset(reset), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ic[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_register #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut_flow (
    .clk(clk), .reset(reset), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ic[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1])
  );

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Reference model: list of held beats {ctrl,data}, head at index 0.
  logic [BW-1:0] mb [2][2];
  int            cnt [2];
  logic [DW-1:0] last_d [2];
  logic [1:0]    hold;

  task automatic check(string tag, logic [159:0] got, logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_ready(int k);
    if (k == 0) return (cnt[0] < 2);
    return (cnt[1] == 0) || ordy[1];
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    for (int w = 0; w < 5; w++) t[w*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      cnt[k]    = 0;
      last_d[k] = '0;
      hold[k]   = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      ec = (cnt[k] > 0) ? mb[k][0][BW-1:DW] : '0;
      ed = (cnt[k] > 0) ? mb[k][0][DW-1:0] : last_d[k];
      check($sformatf("out_valid[%0d]", k), 160'(ov[k]), 160'(cnt[k] > 0));
      check($sformatf("out_ctrl[%0d]", k), 160'(oc[k]), 160'(ec));
      check($sformatf("out_data[%0d]", k), 160'(od[k]), 160'(ed));
      check($sformatf("occupancy[%0d]", k), 160'(occ[k]), 160'(cnt[k]));
      check($sformatf("in_ready[%0d]", k), 160'(ir[k]), 160'(exp_ready(k)));
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      logic rdy, inf, outf;
      rdy     = exp_ready(k);
      inf     = iv[k] && rdy;
      outf    = (cnt[k] > 0) && ordy[k];
      hold[k] = iv[k] && !rdy;
      if (fl[k]) begin
        cnt[k] = 0;
      end else begin
        if (outf) begin
          mb[k][0] = mb[k][1];
          cnt[k]--;
        end
        if (inf) begin
          mb[k][cnt[k]] = {ic[k], id[k]};
          cnt[k]++;
        end
      end
      if (cnt[k] > 0) last_d[k] = mb[k][0][DW-1:0];
    end
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    if (reset) model_clear();
    else update_model();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_all();
    iv = 2'b00; fl = 2'b00; ordy = 2'b11;
    for (int k = 0; k < 2; k++) begin
      ic[k] = '0;
      id[k] = '0;
    end
  endtask

  initial begin
    logic [DW-1:0] bubble_d;
    idle_all();
    model_clear();
    reset = 1'b1;

    // Reset for two cycles: everything zero, in_ready high on both.
    cycle();
    cycle();
    reset = 1'b0;

    // Stream 0x1..0x8 into both instances with out_ready high.
    for (int i = 1; i <= 8; i++) begin
      iv = 2'b11;
      for (int k = 0; k < 2; k++) begin
        ic[k] = CW'(i);
        id[k] = DW'(i);
      end
      cycle();
    end
    iv = 2'b00;
    cycle();
    cycle();

    // Stall/skid on the skid instance: 0xA, 0xB, 0xC with out_ready low.
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      ic[0] = CW'(i + 1);
      id[0] = DW'(32'hA + i);
      cycle();
    end
    cycle();
    check("stall_occupancy", 160'(occ[0]), 160'(2));
    check("stall_in_ready", 160'(ir[0]), 160'(0));
    ordy[0] = 1'b1;
    for (int b = 0; b < 10 && hold[0]; b++) cycle();
    iv[0] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Flush with full skid buffer (ctrl 0x7FF); 0xD offered with the flush.
    ordy[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[0] = 1'b1;
      ic[0] = CW'(11'h7FF);
      id[0] = rnd_data();
      cycle();
    end
    iv = 2'b11; fl = 2'b11; ordy[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ic[k] = CW'(11'h7FF);
      id[k] = DW'(32'hD);
    end
    cycle();
    iv = 2'b00; fl = 2'b00; ordy = 2'b11;
    #1;
    check("flush_out_valid", 160'(ov[0]), 160'(0));
    check("flush_out_ctrl", 160'(oc[0]), 160'(0));
    check("flush_occupancy", 160'(occ[0]), 160'(0));
    check("flush_in_ready", 160'(ir[0]), 160'(1));
    check("flush_drop_flow", 160'(ov[1]), 160'(0));
    for (int i = 0; i < 3; i++) cycle();

    // Bubble controls: one beat with ctrl 0x155, then three idle cycles.
    bubble_d = rnd_data();
    iv = 2'b11;
    for (int k = 0; k < 2; k++) begin
      ic[k] = CW'(11'h155);
      id[k] = bubble_d;
    end
    cycle();
    iv = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
    check("bubble_ctrl", 160'(oc[0]), 160'(0));
    check("bubble_data_hold", 160'(od[1]), 160'(bubble_d));

    // Pass-through instance: out_ready toggling 1,0,1,0 under continuous input.
    for (int i = 0; i < 12; i++) begin
      if (!hold[1]) begin
        iv[1] = 1'b1;
        ic[1] = CW'($urandom);
        id[1] = rnd_data();
      end
      ordy[1] = (i % 2 == 0);
      cycle();
    end
    iv = 2'b00; ordy = 2'b11;
    cycle();
    cycle();

    // Randomised traffic with occasional flushes.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          iv[k] = ($urandom_range(3) != 0);
          ic[k] = CW'($urandom);
          id[k] = rnd_data();
        end
        ordy[k] = ($urandom_range(9) < 7);
        fl[k]   = ($urandom_range(19) == 0);
      end
      cycle();
    end

    // Async reset mid-stall: fill both, then reset between clock edges.
    idle_all();
    cycle();
    ordy = 2'b00;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          iv[k] = 1'b1;
          ic[k] = CW'($urandom) | CW'(1);
          id[k] = rnd_data() | DW'(1);
        end
      end
      cycle();
    end
    check("prereset_occupancy", 160'(occ[0]), 160'(2));
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_out_valid[%0d]", k), 160'(ov[k]), 160'(0));
      check($sformatf("async_out_ctrl[%0d]", k), 160'(oc[k]), 160'(0));
      check($sformatf("async_out_data[%0d]", k), 160'(od[k]), 160'(0));
      check($sformatf("async_occupancy[%0d]", k), 160'(occ[k]), 160'(0));
    end
    model_clear();
    iv = 2'b00;
    @(negedge clk);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
